// File: rtl/accelerator_convolutional_fnn_w_feeder.sv
// Weight feeder for the convolutional FNN accelerator: buffers an L x X weight
// matrix and streams it element by element, paced by the accelerator acknowledge.
module accelerator_convolutional_fnn_w_feeder #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 4,
  parameter int MAX_L        = 8,
  parameter int MAX_X        = 8,
  parameter int ADDRESS_SIZE = 6
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    LOAD_ENABLE,
  input  logic [ADDRESS_SIZE-1:0] LOAD_ADDRESS,
  input  logic [DATA_SIZE-1:0]    LOAD_DATA,
  input  logic [DATA_SIZE-1:0]    SIZE_L_IN,
  input  logic [DATA_SIZE-1:0]    SIZE_X_IN,
  input  logic                    START,
  output logic                    READY,
  output logic                    ERROR,
  output logic [DATA_SIZE-1:0]    W_IN,
  output logic                    W_IN_L_ENABLE,
  output logic                    W_IN_X_ENABLE,
  input  logic                    W_OUT_X_ENABLE
);

  localparam int DEPTH = MAX_L * MAX_X;
  localparam int LW    = (MAX_L > 1) ? $clog2(MAX_L) : 1;
  localparam int XW    = (MAX_X > 1) ? $clog2(MAX_X) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [DATA_SIZE-1:0]    r_mem [DEPTH];
  logic [LW-1:0]           r_l, w_l_nxt, r_size_l_m1, w_size_l_m1_nxt;
  logic [XW-1:0]           r_x, w_x_nxt, r_size_x_m1, w_size_x_m1_nxt;
  logic                    r_err, w_err_nxt;
  logic [DATA_SIZE-1:0]    r_w_in, w_w_in_nxt;
  logic                    r_x_en, w_x_en_nxt;
  logic                    r_l_en, w_l_en_nxt;
  logic                    r_ready, w_ready_nxt;
  logic                    r_error, w_error_nxt;
  logic [ADDRESS_SIZE-1:0] w_rd_addr;
  logic                    w_wr_en;
  logic                    w_size_bad;
  logic [CONTROL_SIZE-1:0] w_unused_control;

  assign w_unused_control = {CONTROL_SIZE{1'b0}};

  assign w_rd_addr = ADDRESS_SIZE'(r_l) * ADDRESS_SIZE'(MAX_X) + ADDRESS_SIZE'(r_x);
  assign w_wr_en   = LOAD_ENABLE && (r_state == S_IDLE) && (32'(LOAD_ADDRESS) < 32'(DEPTH));

  assign w_size_bad = (SIZE_L_IN == {DATA_SIZE{1'b0}}) ||
                      (SIZE_X_IN == {DATA_SIZE{1'b0}}) ||
                      (SIZE_L_IN > DATA_SIZE'(MAX_L))  ||
                      (SIZE_X_IN > DATA_SIZE'(MAX_X));

  // Weight buffer write port; contents deliberately survive reset
  always_ff @(posedge CLK) begin
    if (w_wr_en) begin
      r_mem[LOAD_ADDRESS] <= LOAD_DATA;
    end
  end

  // Next-state, counter and output computation
  always_comb begin
    w_state_nxt     = r_state;
    w_l_nxt         = r_l;
    w_x_nxt         = r_x;
    w_size_l_m1_nxt = r_size_l_m1;
    w_size_x_m1_nxt = r_size_x_m1;
    w_err_nxt       = r_err;
    w_w_in_nxt      = r_w_in;
    w_x_en_nxt      = 1'b0;
    w_l_en_nxt      = 1'b0;
    w_ready_nxt     = 1'b0;
    w_error_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          // Sizes are kept as (size-1) truncated to counter width
          w_size_l_m1_nxt = LW'(SIZE_L_IN - DATA_SIZE'(1));
          w_size_x_m1_nxt = XW'(SIZE_X_IN - DATA_SIZE'(1));
          w_l_nxt         = {LW{1'b0}};
          w_x_nxt         = {XW{1'b0}};
          if (w_size_bad) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_ISSUE;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        w_w_in_nxt  = r_mem[w_rd_addr];
        w_x_en_nxt  = 1'b1;
        w_l_en_nxt  = (r_x == {XW{1'b0}});
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (W_OUT_X_ENABLE) begin
          if (r_x < r_size_x_m1) begin
            w_x_nxt     = r_x + XW'(1);
            w_state_nxt = S_ISSUE;
          end else begin
            w_x_nxt = {XW{1'b0}};
            if (r_l < r_size_l_m1) begin
              w_l_nxt     = r_l + LW'(1);
              w_state_nxt = S_ISSUE;
            end else begin
              w_state_nxt = S_DONE;
            end
          end
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_DONE: begin
        w_ready_nxt = 1'b1;
        w_error_nxt = r_err;
        w_err_nxt   = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= S_IDLE;
      r_l         <= {LW{1'b0}};
      r_x         <= {XW{1'b0}};
      r_size_l_m1 <= {LW{1'b0}};
      r_size_x_m1 <= {XW{1'b0}};
      r_err       <= 1'b0;
      r_w_in      <= {DATA_SIZE{1'b0}};
      r_x_en      <= 1'b0;
      r_l_en      <= 1'b0;
      r_ready     <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_l         <= w_l_nxt;
      r_x         <= w_x_nxt;
      r_size_l_m1 <= w_size_l_m1_nxt;
      r_size_x_m1 <= w_size_x_m1_nxt;
      r_err       <= w_err_nxt;
      r_w_in      <= w_w_in_nxt;
      r_x_en      <= w_x_en_nxt;
      r_l_en      <= w_l_en_nxt;
      r_ready     <= w_ready_nxt;
      r_error     <= w_error_nxt;
    end
  end

  assign W_IN          = r_w_in;
  assign W_IN_X_ENABLE = r_x_en;
  assign W_IN_L_ENABLE = r_l_en;
  assign READY         = r_ready;
  assign ERROR         = r_error;

endmodule

// File: tb/tb_accelerator_convolutional_fnn_w_feeder.sv
// Self-checking bench for the weight feeder: table-driven runs plus random runs,
// checked against a row-major matrix model of the weight buffer.
module tb_accelerator_convolutional_fnn_w_feeder;

  localparam int DW = 64;
  localparam int AW = 6;
  localparam int ML = 8;
  localparam int MX = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          LOAD_ENABLE;
  logic [AW-1:0] LOAD_ADDRESS;
  logic [DW-1:0] LOAD_DATA;
  logic [DW-1:0] SIZE_L_IN;
  logic [DW-1:0] SIZE_X_IN;
  logic          START;
  logic          READY;
  logic          ERROR;
  logic [DW-1:0] W_IN;
  logic          W_IN_L_ENABLE;
  logic          W_IN_X_ENABLE;
  logic          W_OUT_X_ENABLE;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] model_mem [ML*MX];

  typedef struct {
    int sl;
    int sx;
    int d;          // acknowledge delay in cycles after each pulse; 0 = held high
    bit inject;     // pulse START + LOAD(addr 0, 99) mid-run
    int abort_at;   // drop RST after this many pulses; 0 = never
    bit exp_err;
    int exp_pulses;
  } vec_t;

  vec_t vecs[$];

  always #5 CLK = ~CLK;

  accelerator_convolutional_fnn_w_feeder dut (
    .CLK            (CLK),
    .RST            (RST),
    .LOAD_ENABLE    (LOAD_ENABLE),
    .LOAD_ADDRESS   (LOAD_ADDRESS),
    .LOAD_DATA      (LOAD_DATA),
    .SIZE_L_IN      (SIZE_L_IN),
    .SIZE_X_IN      (SIZE_X_IN),
    .START          (START),
    .READY          (READY),
    .ERROR          (ERROR),
    .W_IN           (W_IN),
    .W_IN_L_ENABLE  (W_IN_L_ENABLE),
    .W_IN_X_ENABLE  (W_IN_X_ENABLE),
    .W_OUT_X_ENABLE (W_OUT_X_ENABLE)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load_word(input int addr, input logic [DW-1:0] data);
    @(negedge CLK);
    LOAD_ENABLE  = 1'b1;
    LOAD_ADDRESS = AW'(addr);
    LOAD_DATA    = data;
    @(negedge CLK);
    LOAD_ENABLE  = 1'b0;
    model_mem[addr] = data;
  endtask

  task automatic run_stream(input string name, input vec_t v);
    logic [DW-1:0] expq[$];
    bit            rowq[$];
    int pulses = 0, rows = 0, cyc = 0, ack_cnt = 0, since_ack = -100;
    int first_cyc = -1, ready_cyc = -1, ready_gap = -1;
    int hold_bad = 0, stray = 0, late = 0;
    bit ready_err = 1'b0;
    bit aborted = 1'b0;
    logic [DW-1:0] held = '0;

    // Reference: row-major walk of the active L x X window of the buffer
    if (!(v.sl == 0 || v.sx == 0 || v.sl > ML || v.sx > MX)) begin
      for (int l = 0; l < v.sl; l++) begin
        for (int x = 0; x < v.sx; x++) begin
          expq.push_back(model_mem[l*MX + x]);
          rowq.push_back(x == 0);
        end
      end
    end

    @(negedge CLK);
    SIZE_L_IN      = DW'(v.sl);
    SIZE_X_IN      = DW'(v.sx);
    START          = 1'b1;
    W_OUT_X_ENABLE = (v.d == 0);
    while (ready_cyc < 0 && !aborted && cyc < 3000) begin
      @(negedge CLK);
      cyc++;
      since_ack++;
      START       = 1'b0;
      LOAD_ENABLE = 1'b0;
      if (READY) begin
        ready_cyc = cyc;
        ready_gap = since_ack;
        ready_err = ERROR;
      end
      if (W_IN_X_ENABLE) begin
        if (pulses < expq.size()) begin
          check({name, " w_in"}, W_IN, expq[pulses]);
          check({name, " row_en"}, DW'(W_IN_L_ENABLE), DW'(rowq[pulses]));
        end else begin
          stray++;
        end
        if (W_IN_L_ENABLE) rows++;
        if (pulses == 0) first_cyc = cyc;
        pulses++;
        held    = W_IN;
        ack_cnt = v.d;
        if (v.d == 0) since_ack = 0;
        else W_OUT_X_ENABLE = 1'b0;
        if (v.inject && pulses == 2) begin
          START        = 1'b1;
          LOAD_ENABLE  = 1'b1;
          LOAD_ADDRESS = '0;
          LOAD_DATA    = DW'(99);
        end
        if (v.abort_at == pulses) begin
          RST = 1'b0;
          #1;
          check({name, " rst w_in"}, W_IN, '0);
          check({name, " rst x_en"}, DW'(W_IN_X_ENABLE), '0);
          check({name, " rst l_en"}, DW'(W_IN_L_ENABLE), '0);
          check({name, " rst ready/error"}, DW'({READY, ERROR}), '0);
          aborted = 1'b1;
        end
      end else begin
        if (pulses > 0 && W_IN !== held) hold_bad++;
        if (W_IN_L_ENABLE) stray++;
        if (v.d > 0) begin
          if (ack_cnt > 0) begin
            ack_cnt--;
            W_OUT_X_ENABLE = (ack_cnt == 0);
            if (ack_cnt == 0) since_ack = 0;
          end else begin
            W_OUT_X_ENABLE = 1'b0;
          end
        end
      end
    end
    W_OUT_X_ENABLE = 1'b0;
    START          = 1'b0;
    LOAD_ENABLE    = 1'b0;

    if (aborted) begin
      repeat (3) begin
        @(negedge CLK);
        if (READY || W_IN_X_ENABLE) late++;
      end
      RST = 1'b1;
      repeat (3) begin
        @(negedge CLK);
        if (READY || W_IN_X_ENABLE) late++;
      end
      check({name, " no ready after reset"}, DW'(late), '0);
    end else begin
      check({name, " ready seen"}, DW'(ready_cyc >= 0), DW'(1));
      check({name, " error"}, DW'(ready_err), DW'(v.exp_err));
      check({name, " pulses"}, DW'(pulses), DW'(v.exp_pulses));
      check({name, " row pulses"}, DW'(rows), DW'(v.exp_err ? 0 : v.sl));
      check({name, " hold/stray"}, DW'(hold_bad + stray), '0);
      if (v.exp_err) check({name, " error latency"}, DW'(ready_cyc), DW'(2));
      else begin
        check({name, " first pulse latency"}, DW'(first_cyc), DW'(2));
        check({name, " ready after last ack"}, DW'(ready_gap), DW'(2));
      end
      repeat (3) begin
        @(negedge CLK);
        if (READY || ERROR || W_IN_X_ENABLE) late++;
      end
      check({name, " quiet after ready"}, DW'(late), '0);
    end
  endtask

  initial begin
    vec_t rv;
    RST            = 1'b0;
    LOAD_ENABLE    = 1'b0;
    LOAD_ADDRESS   = '0;
    LOAD_DATA      = '0;
    SIZE_L_IN      = '0;
    SIZE_X_IN      = '0;
    START          = 1'b0;
    W_OUT_X_ENABLE = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset w_in", W_IN, '0);
    check("reset flags", DW'({READY, ERROR, W_IN_L_ENABLE, W_IN_X_ENABLE}), '0);
    RST = 1'b1;

    for (int a = 0; a < ML*MX; a++) load_word(a, {$urandom, $urandom});
    for (int l = 0; l < 2; l++)
      for (int x = 0; x < 3; x++) load_word(l*MX + x, DW'(10 + l*3 + x));

    //            sl  sx  d  inj abort err pulses
    vecs.push_back('{2, 3, 1, 1'b0, 0, 1'b0, 6});
    vecs.push_back('{2, 3, 4, 1'b0, 0, 1'b0, 6});
    vecs.push_back('{0, 3, 1, 1'b0, 0, 1'b1, 0});
    vecs.push_back('{9, 1, 1, 1'b0, 0, 1'b1, 0});
    vecs.push_back('{3, 0, 1, 1'b0, 0, 1'b1, 0});
    vecs.push_back('{1, 9, 1, 1'b0, 0, 1'b1, 0});
    vecs.push_back('{2, 3, 2, 1'b1, 0, 1'b0, 6});
    vecs.push_back('{1, 1, 1, 1'b0, 0, 1'b0, 1});
    vecs.push_back('{8, 8, 1, 1'b0, 3, 1'b0, 3});
    vecs.push_back('{1, 1, 2, 1'b0, 0, 1'b0, 1});
    vecs.push_back('{8, 8, 0, 1'b0, 0, 1'b0, 64});
    vecs.push_back('{8, 1, 1, 1'b0, 0, 1'b0, 8});
    vecs.push_back('{1, 8, 3, 1'b0, 0, 1'b0, 8});

    foreach (vecs[i]) run_stream($sformatf("vec%0d", i), vecs[i]);

    // Random runs with buffer rewrites between them
    for (int r = 0; r < 12; r++) begin
      load_word(int'($urandom_range(0, ML*MX-1)), {$urandom, $urandom});
      rv.sl         = int'($urandom_range(0, 9));
      rv.sx         = int'($urandom_range(0, 9));
      rv.d          = int'($urandom_range(0, 3));
      rv.inject     = 1'b0;
      rv.abort_at   = 0;
      rv.exp_err    = (rv.sl == 0 || rv.sx == 0 || rv.sl > ML || rv.sx > MX);
      rv.exp_pulses = rv.exp_err ? 0 : rv.sl * rv.sx;
      run_stream($sformatf("rand%0d", r), rv);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
